// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and the handler entry address used by the pipeline flush.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int IM_HI  = 15;
  localparam int IM_LO  = 10;
  localparam int EXL    = 1;
  localparam int IE     = 0;
  localparam int BD     = 31;
  localparam int IP_HI  = 15;
  localparam int IP_LO  = 10;
  localparam int EXC_HI = 6;
  localparam int EXC_LO = 2;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0_req_arb.sv
// Combinational exception/interrupt arbiter: decides whether the M-stage
// instruction is flushed and which ExcCode gets recorded.
module cp0_req_arb
  import cp0_pkg::*;
#(
  parameter int INT_W = 6
) (
  input  logic [INT_W-1:0] i_im,
  input  logic [INT_W-1:0] i_hw_int,
  input  logic             i_ie,
  input  logic             i_exl,
  input  logic [4:0]       i_exc_code,
  output logic             o_req,
  output logic [4:0]       o_exc_code
);

  logic w_int_req;
  logic w_exc_req;

  assign w_int_req  = i_ie & ~i_exl & (|(i_im & i_hw_int));
  assign w_exc_req  = (i_exc_code != EXC_INT) & ~i_exl;
  assign o_req      = w_int_req | w_exc_req;
  // An interrupt outranks a synchronous exception in the same cycle.
  assign o_exc_code = w_int_req ? EXC_INT : i_exc_code;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 at the M stage: holds SR/Cause/EPC/PRId, raises the flush
// request and serves mfc0 reads and the eret target.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID  = 32'h0000_2022,
  parameter int          INT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       i_a1,
  input  logic [4:0]       i_a2,
  input  logic [31:0]      i_din,
  input  logic             i_we,
  input  logic [31:0]      i_pc,
  input  logic             i_bd,
  input  logic [4:0]       i_exc_code,
  input  logic             i_exl_clr,
  input  logic [INT_W-1:0] i_hw_int,
  output logic             o_req,
  output logic [31:0]      o_epc,
  output logic [31:0]      o_dout
);

  logic [INT_W-1:0] r_im;
  logic             r_exl;
  logic             r_ie;
  logic             r_cause_bd;
  logic [INT_W-1:0] r_ip;
  logic [4:0]       r_exc_code;
  logic [31:0]      r_epc;

  logic             w_req;
  logic [4:0]       w_exc_sel;
  logic [31:0]      w_epc_next;
  logic [31:0]      w_sr;
  logic [31:0]      w_cause;
  logic [31:0]      w_dout;

  cp0_req_arb #(.INT_W(INT_W)) u_req_arb (
    .i_im       (r_im),
    .i_hw_int   (i_hw_int),
    .i_ie       (r_ie),
    .i_exl      (r_exl),
    .i_exc_code (i_exc_code),
    .o_req      (w_req),
    .o_exc_code (w_exc_sel)
  );

  // A delay-slot instruction restarts at its branch; subtraction wraps.
  assign w_epc_next = (i_bd ? (i_pc - 32'd4) : i_pc) & ~32'd3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_cause_bd <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
    end else begin
      r_ip <= i_hw_int;
      if (w_req) begin
        r_exl      <= 1'b1;
        r_cause_bd <= i_bd;
        r_exc_code <= w_exc_sel;
        r_epc      <= w_epc_next;
      end else begin
        if (i_we && (i_a2 == REG_SR)) begin
          r_im  <= i_din[IM_LO +: INT_W];
          r_exl <= i_din[EXL];
          r_ie  <= i_din[IE];
        end
        if (i_we && (i_a2 == REG_EPC)) begin
          r_epc <= {i_din[31:2], 2'b00};
        end
        // eret overrides an EXL value written by a concurrent mtc0.
        if (i_exl_clr) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_sr                  = '0;
    w_sr[IM_LO +: INT_W]  = r_im;
    w_sr[EXL]             = r_exl;
    w_sr[IE]              = r_ie;
    w_cause               = '0;
    w_cause[BD]           = r_cause_bd;
    w_cause[IP_LO +: INT_W] = r_ip;
    w_cause[EXC_HI:EXC_LO]  = r_exc_code;
  end

  always_comb begin
    w_dout = '0;
    case (i_a1)
      REG_SR:    w_dout = w_sr;
      REG_CAUSE: w_dout = w_cause;
      REG_EPC:   w_dout = r_epc;
      REG_PRID:  w_dout = PRID;
      default:   w_dout = '0;
    endcase
  end

  assign o_req  = w_req;
  assign o_epc  = r_epc;
  assign o_dout = w_dout;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: hand-computed expectations checked with
// immediate assertions after each step.
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  a1, a2;
  logic [31:0] din;
  logic        we;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exc_code;
  logic        exl_clr;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] epc;
  logic [31:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  cp0_exc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .i_a1       (a1),
    .i_a2       (a2),
    .i_din      (din),
    .i_we       (we),
    .i_pc       (pc),
    .i_bd       (bd),
    .i_exc_code (exc_code),
    .i_exl_clr  (exl_clr),
    .i_hw_int   (hw_int),
    .o_req      (req),
    .o_epc      (epc),
    .o_dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    a1 = addr;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic idle();
    we = 0; a2 = 0; din = 0; exc_code = 0; exl_clr = 0; bd = 0;
  endtask

  initial begin
    reset = 1; a1 = 0; pc = 0; hw_int = 0;
    idle();
    tick(); tick();
    reset = 0;
    #1;
    chk("reset_req", {31'd0, req}, 32'd0);
    chk("reset_epc", epc, 32'd0);
    rd("prid", 5'd15, 32'h0000_2022);
    rd("sr_rst", 5'd12, 32'd0);
    rd("cause_rst", 5'd13, 32'd0);
    rd("epc_rst", 5'd14, 32'd0);
    rd("other_addr", 5'd5, 32'd0);
    hw_int = 6'h3F;
    #1;
    chk("ie0_no_req", {31'd0, req}, 32'd0);
    tick();
    rd("ip_sampled", 5'd13, 32'h0000_FC00);
    hw_int = 0;

    // Enable IM[10] and IE
    we = 1; a2 = 5'd12; din = 32'h0000_0401;
    tick();
    idle();
    rd("sr_write", 5'd12, 32'h0000_0401);

    // Interrupt at PC 0x3010
    hw_int = 6'b000001; pc = 32'h3010;
    #1;
    chk("int_req", {31'd0, req}, 32'd1);
    tick();
    #1;
    chk("int_masked", {31'd0, req}, 32'd0);
    chk("int_epc", epc, 32'h3010);
    rd("int_sr", 5'd12, 32'h0000_0403);
    rd("int_cause", 5'd13, 32'h0000_0400);

    // eret, then Ov in a delay slot
    hw_int = 0; exl_clr = 1;
    tick();
    idle();
    rd("eret_sr", 5'd12, 32'h0000_0401);
    exc_code = 5'd12; bd = 1; pc = 32'h3024;
    #1;
    chk("ov_req", {31'd0, req}, 32'd1);
    tick();
    idle();
    chk("ov_epc", epc, 32'h3020);
    rd("ov_cause", 5'd13, 32'h8000_0030);
    rd("ov_epc_rd", 5'd14, 32'h3020);

    // mtc0 EPC in the same cycle as an AdEL is dropped
    exl_clr = 1;
    tick();
    idle();
    we = 1; a2 = 5'd14; din = 32'h5000; exc_code = 5'd4; pc = 32'h3100;
    #1;
    chk("adel_req", {31'd0, req}, 32'd1);
    tick();
    idle();
    chk("write_dropped", epc, 32'h3100);
    rd("adel_cause", 5'd13, 32'h0000_0010);
    exc_code = 5'd4;
    #1;
    chk("exl_masks_exc", {31'd0, req}, 32'd0);
    exl_clr = 1;
    tick();
    idle();
    rd("eret2_sr", 5'd12, 32'h0000_0401);
    exc_code = 5'd5; pc = 32'h3200;
    #1;
    chk("fresh_req", {31'd0, req}, 32'd1);
    tick();
    idle();
    chk("fresh_epc", epc, 32'h3200);
    rd("fresh_cause", 5'd13, 32'h0000_0014);

    // Interrupt and RI together: interrupt recorded, one request only
    exl_clr = 1;
    tick();
    idle();
    hw_int = 6'b000001; exc_code = 5'd10; pc = 32'h3300;
    #1;
    chk("both_req", {31'd0, req}, 32'd1);
    tick();
    rd("both_cause", 5'd13, 32'h0000_0400);
    chk("both_epc", epc, 32'h3300);
    chk("both_once", {31'd0, req}, 32'd0);
    tick();
    chk("both_once2", {31'd0, req}, 32'd0);
    chk("both_epc_hold", epc, 32'h3300);

    // Reset while EXL=1
    reset = 1; hw_int = 0; exl_clr = 1; we = 1; a2 = 5'd14; din = 32'h7000;
    tick();
    reset = 0;
    idle();
    rd("rst_sr", 5'd12, 32'd0);
    chk("rst_epc", epc, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);

    // eret beats mtc0 setting EXL
    we = 1; a2 = 5'd12; din = 32'h0000_0403; exl_clr = 1;
    #1;
    chk("wr_no_req", {31'd0, req}, 32'd0);
    tick();
    idle();
    rd("exlclr_wins", 5'd12, 32'h0000_0401);

    // EPC write: low bits cleared, not bypassed
    we = 1; a2 = 5'd14; din = 32'h5003;
    #1;
    chk("epc_no_bypass", epc, 32'd0);
    tick();
    idle();
    chk("epc_write", epc, 32'h5000);

    // Cause is read-only
    we = 1; a2 = 5'd13; din = 32'hFFFF_FFFF;
    tick();
    idle();
    rd("cause_ro", 5'd13, 32'd0);

    // PC-4 wrap
    exc_code = 5'd8; bd = 1; pc = 32'd0;
    #1;
    chk("wrap_req", {31'd0, req}, 32'd1);
    tick();
    idle();
    chk("wrap_epc", epc, 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0020);

    // SR reserved bits ignore writes
    we = 1; a2 = 5'd12; din = 32'hFFFF_FFFF;
    tick();
    idle();
    rd("sr_mask", 5'd12, 32'h0000_FC03);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller sitting at the M stage.
- Consumes M-stage PC, BD and ExcCode together with mtc0/eret controls and the external HWInt lines.
- Produces the Req flush that every pipeline register uses to load the 0x4180 handler bubble, and supplies EPC for eret and mfc0 read data.
- Owns SR, Cause, EPC and PRId.

Parameters:
- PRID, 32'h0000_2022, constant value returned for register 15.
- INT_W, 6, number of hardware interrupt lines (maps to IM/IP bits 15:10).

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable (M stage).
- PC  in  32  M-stage PC.
- BD  in  1  M-stage instruction sits in a delay slot.
- ExcCodeIn  in  5  M-stage exception code; 0 means none.
- EXLClr  in  1  eret in M stage.
- HWInt  in  INT_W  external interrupt levels.
- Req  out  1  exception/interrupt taken this cycle (combinational).
- EPCOut  out  32  current EPC register (eret target).
- DOut  out  32  combinational read of register A1.

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk. Reset values: SR=0, Cause=0, EPC=0. After reset, Req=0, EPCOut=0 and DOut follows A1.
- SR (12) fields: IM=[15:10], EXL=[1], IE=[0]. All other bits read 0 and ignore writes.
- Cause (13) fields: BD=[31], IP=[15:10], ExcCode=[6:2]. All other bits read 0.
- EPC (14): full 32 bits, bits[1:0] forced to 0 on load.
- PRId (15) reads PRID. Any other A1 reads 0.
- Request logic, combinational from current state and inputs:
  - IntReq = IE & !EXL & |(IM & HWInt).
  - ExcReq = (ExcCodeIn != 0) & !EXL.
  - Req = IntReq | ExcReq. Interrupt takes priority over exception.
- On a clock edge with Req=1:
  - EXL<=1.
  - Cause.BD<=BD.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn.
  - EPC <= BD ? PC-4 : PC, with low 2 bits cleared.
  - Any simultaneous WE write is discarded; the M instruction is flushed.
  - Any simultaneous EXLClr is ignored.
- Clock edge with Req=0:
  - If WE, write the addressed register. A2=12 writes the IM/EXL/IE bits; A2=14 writes EPC.
  - Writes to Cause, PRId or other addresses are ignored.
  - Then, if EXLClr, EXL<=0. EXLClr wins over a simultaneous mtc0 EXL bit.
- IP <= HWInt every cycle, regardless of Req, WE or EXL. IP is sampled, so DOut shows the previous cycle's HWInt.
- EPCOut = EPC register. A write at edge N is visible from cycle N+1, with no bypass.
- DOut reflects register contents before the current edge (read-before-write).
- EXL=1 masks both interrupts and exceptions, so nested Req is impossible until eret.
- Reset asserted mid-handler clears EXL and EPC unconditionally. Reset dominates Req, WE and EXLClr.
- PC-4 wraps modulo 2^32 (PC=0 with BD gives 0xFFFF_FFFC).

Decomposition:
- Shared package cp0_pkg holds:
  - register numbers (SR=12, CAUSE=13, EPC=14, PRID=15);
  - field bit positions (IM_HI/LO, EXL, IE, BD, IP_HI/LO, EXC_HI/LO);
  - ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12, Syscall=8);
  - the handler address 32'h0000_4180, shared with the pipeline registers.
- Sub-module cp0_req_arb (combinational): computes IntReq, ExcReq, Req and the selected ExcCode. It is unit-testable on its own.

Test Plan:
- Reset, then mfc0 A1=15 -> DOut=PRID. A1=12/13/14 -> 0. Req=0 even with HWInt=6'h3F, because IE=0.
- mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), then HWInt=6'b000001 at M PC=0x3010, BD=0 -> Req=1 that cycle.
  - Next cycle: EPCOut=0x3010, Cause.ExcCode=0, EXL=1, Req=0 while HWInt is held.
- ExcCodeIn=5'd12 (Ov) with BD=1, PC=0x3024, EXL=0 -> Req=1.
  - Next cycle: EPC=0x3020, Cause=32'h8000_0030 plus IP bits.
- Same cycle WE=1, A2=14, DIn=0x5000 and ExcCodeIn=4 -> EPC=PC (write dropped).
  - Then eret (EXLClr=1) -> EXL=0; a fresh exception is accepted on the following cycle.
- Interrupt and ExcCodeIn=10 in the same cycle -> ExcCode=0 recorded, Req=1 once only.
  - Reset asserted while EXL=1 -> SR=0 and EPC=0 next cycle.
